id_decode_control: RTL and testbench
====================================

# id_decode_control

Instruction-decode control block for the 5-stage ARM-subset pipeline (PPU). It decodes the 32-bit IF/ID instruction into ID-stage control signals, inserts a bubble (all-zero controls) on a hazard stall, and resolves conditional B/BL. It also holds a one-cycle ALU flag register and selects the flag source used for condition evaluation.

## Interface
- Parameters: none.
- `clk` in 1: single clock; flag register samples on the rising edge.
- `R` in 1: asynchronous, active-high reset.
- `instruction` in 32: IF/ID instruction word.
- `S` in 1: stall/bubble select from forwarding unit; 1 = force NOP controls.
- `alu_nzcv` in 4: live EX ALU flags {N,Z,C,V}.
- `psr_flags` in 4: PSR register flags {N,Z,C,V}.
- `ex_s_enable` in 1: S bit of instruction currently in EX.
- `ID_opcode` out 4, `ID_AM` out 2: ALU opcode, addressing mode.
- `ID_S_enable`, `ID_load_instr`, `ID_RF_enable`, `ID_Size_enable`, `ID_RW_enable`, `ID_Enable_signal`, `ID_BL_instr`, `ID_B_instr` out 1 each.
- `Branch`, `BranchL` out 1: taken branch / taken branch-with-link.
- `keyword` out 48: 6-char ASCII mnemonic, space padded (debug).

## Operation
- Decode (combinational, on `instruction`):
  - 0x00000000: NOP, all controls 0, keyword "NOP   ".
  - Data processing, [27:26]=00: opcode=[24:21], S_enable=[20]. AM=00 if I=[25]=1 (rotated imm8), else 01 (shift by imm). RF_enable=1 except TST/TEQ/CMP/CMN (1000–1011). Mem controls 0.
  - Load/store, [27:26]=01: opcode=0100 (ADD) if U=[23]=1, else 0010 (SUB).
    - AM=10 if [25]=0 (imm12 offset), else 11 (register offset).
    - load_instr=L=[20]; RF_enable=L; RW_enable=~L (1 = write).
    - Enable_signal=1; Size_enable=B=[22] (1 = byte); S_enable=0.
  - Branch, [27:25]=101: B_instr=1; BL_instr=[24]; opcode=0100; AM=00; all other controls 0.
  - Any other encoding: all controls 0, keyword "UNDEF ".
- Bubble mux: S=1 forces every ID_* output to 0; S=0 passes decode through.
- Flag register `flags_q`: loads `alu_nzcv` every rising edge.
- Flag select: `ex_s_enable`=1 uses `flags_q`, else `psr_flags`.
- Condition handler: cond=`instruction`[31:28] tested against the selected flags with standard ARM semantics (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL). 1111 = never.
  - Branch = ID_B_instr & cond_true.
  - BranchL = ID_BL_instr & cond_true.
  - Uses post-mux controls, so a stalled branch is never taken.

## Timing
- All decode, mux and condition outputs are combinational; zero latency from `instruction`, `S` and the flags.
- `flags_q` reset value 0000. R clears it immediately, independent of `clk`.
- Reset-state outputs follow the inputs. With R=1 and instruction=0, every output is 0 and keyword is "NOP   ".
- `flags_q` reflects `alu_nzcv` one cycle after it is presented.
- S and a branch in the same cycle: S wins; Branch=BranchL=0.

## Configuration
- `CU_KEYWORD_EN` defined: `keyword` carries the decoded mnemonic (e.g. "ADD   ", "LDR   ", "STRB  ", "BL    ", "NOP   ").
- `CU_KEYWORD_EN` undefined: `keyword` is tied to 48'h0 and the mnemonic logic is removed.
- All other behaviour is identical either way.

## Test plan
- ADDS r1,r2,#5 (0xE2921005), S=0: opcode=0100, AM=00, S_enable=1, RF_enable=1, mem controls 0, Branch=0.
- LDRB r3,[r1,#4] (0xE5D13004): load_instr=1, RF_enable=1, Enable=1, RW=0, Size=1, AM=10, opcode=0100. Repeat with S=1: all ID_* = 0.
- CMP r1,r2 (0xE1510002): opcode=1010, S_enable=1, RF_enable=0, AM=01.
- BEQ (0x0A000003) with ex_s_enable=0:
  - psr_flags=0100 (Z=1): Branch=1, BranchL=0.
  - psr_flags=0000: Branch=0.
- BL (0xEB000002): B_instr=1, BL_instr=1, Branch=1, BranchL=1.
  - Also set ex_s_enable=1 with alu_nzcv=0100 clocked in, then check BNE (0x1A000001): Branch=0.
- Assert R mid-run after `flags_q`=1111: `flags_q` returns to 0000 without a clock edge. A GE branch with ex_s_enable=1 is then taken (N=V=0).

Source files
------------

// File: rtl/id_decode_control_if.sv
// Interface bundling the decode inputs and the ID-stage control outputs of
// id_decode_control. The slave modport is the decoder; master is its driver.
interface id_decode_control_if;
  logic [31:0] instruction;
  logic        S;
  logic [3:0]  alu_nzcv;
  logic [3:0]  psr_flags;
  logic        ex_s_enable;

  logic [3:0]  ID_opcode;
  logic [1:0]  ID_AM;
  logic        ID_S_enable;
  logic        ID_load_instr;
  logic        ID_RF_enable;
  logic        ID_Size_enable;
  logic        ID_RW_enable;
  logic        ID_Enable_signal;
  logic        ID_BL_instr;
  logic        ID_B_instr;
  logic        Branch;
  logic        BranchL;
  logic [47:0] keyword;

  modport master (
    output instruction, S, alu_nzcv, psr_flags, ex_s_enable,
    input  ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
           ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr,
           ID_B_instr, Branch, BranchL, keyword
  );

  modport slave (
    input  instruction, S, alu_nzcv, psr_flags, ex_s_enable,
    output ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
           ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr,
           ID_B_instr, Branch, BranchL, keyword
  );
endinterface

// File: rtl/id_decode_control.sv
// ID-stage control unit for the 5-stage ARM-subset pipeline.
// Decodes the IF/ID instruction into control signals, forces a bubble on
// stall, keeps a one-cycle copy of the EX ALU flags and resolves B/BL
// conditions against either that copy or the PSR flags.
// Optional: define CU_KEYWORD_EN to drive the 6-char ASCII mnemonic on
// keyword; otherwise keyword is tied to zero.
module id_decode_control (
  input logic             clk,
  input logic             R,
  id_decode_control_if.slave bus
);

  logic [31:0] instr;
  logic [3:0]  dec_opcode;
  logic [1:0]  dec_am;
  logic        dec_s_enable;
  logic        dec_load;
  logic        dec_rf;
  logic        dec_size;
  logic        dec_rw;
  logic        dec_en;
  logic        dec_bl;
  logic        dec_b;

  logic        post_b;
  logic        post_bl;
  logic [3:0]  flags_q;
  logic [3:0]  sel_flags;
  logic        cond_true;
  logic        unused_bits;

  assign instr       = bus.instruction;
  assign unused_bits = ^instr[19:0];

  // Raw decode of the instruction word into control fields
  always_comb begin
    dec_opcode   = 4'b0000;
    dec_am       = 2'b00;
    dec_s_enable = 1'b0;
    dec_load     = 1'b0;
    dec_rf       = 1'b0;
    dec_size     = 1'b0;
    dec_rw       = 1'b0;
    dec_en       = 1'b0;
    dec_bl       = 1'b0;
    dec_b        = 1'b0;
    if (instr == 32'h0000_0000) begin
      dec_opcode = 4'b0000;
    end else if (instr[27:26] == 2'b00) begin
      dec_opcode   = instr[24:21];
      dec_s_enable = instr[20];
      dec_am       = instr[25] ? 2'b00 : 2'b01;
      dec_rf       = (instr[24:23] != 2'b10);
    end else if (instr[27:26] == 2'b01) begin
      dec_opcode = instr[23] ? 4'b0100 : 4'b0010;
      dec_am     = instr[25] ? 2'b11 : 2'b10;
      dec_load   = instr[20];
      dec_rf     = instr[20];
      dec_rw     = ~instr[20];
      dec_en     = 1'b1;
      dec_size   = instr[22];
    end else if (instr[27:25] == 3'b101) begin
      dec_b      = 1'b1;
      dec_bl     = instr[24];
      dec_opcode = 4'b0100;
    end
  end

  // Bubble mux: a stall replaces every ID control with zero
  always_comb begin
    bus.ID_opcode        = 4'b0000;
    bus.ID_AM            = 2'b00;
    bus.ID_S_enable      = 1'b0;
    bus.ID_load_instr    = 1'b0;
    bus.ID_RF_enable     = 1'b0;
    bus.ID_Size_enable   = 1'b0;
    bus.ID_RW_enable     = 1'b0;
    bus.ID_Enable_signal = 1'b0;
    bus.ID_BL_instr      = 1'b0;
    bus.ID_B_instr       = 1'b0;
    post_b               = 1'b0;
    post_bl              = 1'b0;
    if (!bus.S) begin
      bus.ID_opcode        = dec_opcode;
      bus.ID_AM            = dec_am;
      bus.ID_S_enable      = dec_s_enable;
      bus.ID_load_instr    = dec_load;
      bus.ID_RF_enable     = dec_rf;
      bus.ID_Size_enable   = dec_size;
      bus.ID_RW_enable     = dec_rw;
      bus.ID_Enable_signal = dec_en;
      bus.ID_BL_instr      = dec_bl;
      bus.ID_B_instr       = dec_b;
      post_b               = dec_b;
      post_bl              = dec_bl;
    end
  end

  // One-cycle copy of the EX ALU flags, cleared asynchronously
  always_ff @(posedge clk or posedge R) begin
    if (R) flags_q <= 4'b0000;
    else   flags_q <= bus.alu_nzcv;
  end

  assign sel_flags = bus.ex_s_enable ? flags_q : bus.psr_flags;

  // ARM condition evaluation on the selected {N,Z,C,V}
  always_comb begin
    cond_true = 1'b0;
    case (instr[31:28])
      4'h0: cond_true = sel_flags[2];
      4'h1: cond_true = ~sel_flags[2];
      4'h2: cond_true = sel_flags[1];
      4'h3: cond_true = ~sel_flags[1];
      4'h4: cond_true = sel_flags[3];
      4'h5: cond_true = ~sel_flags[3];
      4'h6: cond_true = sel_flags[0];
      4'h7: cond_true = ~sel_flags[0];
      4'h8: cond_true = sel_flags[1] & ~sel_flags[2];
      4'h9: cond_true = ~sel_flags[1] | sel_flags[2];
      4'hA: cond_true = (sel_flags[3] == sel_flags[0]);
      4'hB: cond_true = (sel_flags[3] != sel_flags[0]);
      4'hC: cond_true = ~sel_flags[2] & (sel_flags[3] == sel_flags[0]);
      4'hD: cond_true = sel_flags[2] | (sel_flags[3] != sel_flags[0]);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign bus.Branch  = post_b & cond_true;
  assign bus.BranchL = post_bl & cond_true;

`ifdef CU_KEYWORD_EN
  // Debug mnemonic of the undecorated instruction (not affected by stall)
  always_comb begin
    bus.keyword = "UNDEF ";
    if (instr == 32'h0000_0000) begin
      bus.keyword = "NOP   ";
    end else if (instr[27:26] == 2'b00) begin
      case (instr[24:21])
        4'h0: bus.keyword = "AND   ";
        4'h1: bus.keyword = "EOR   ";
        4'h2: bus.keyword = "SUB   ";
        4'h3: bus.keyword = "RSB   ";
        4'h4: bus.keyword = "ADD   ";
        4'h5: bus.keyword = "ADC   ";
        4'h6: bus.keyword = "SBC   ";
        4'h7: bus.keyword = "RSC   ";
        4'h8: bus.keyword = "TST   ";
        4'h9: bus.keyword = "TEQ   ";
        4'hA: bus.keyword = "CMP   ";
        4'hB: bus.keyword = "CMN   ";
        4'hC: bus.keyword = "ORR   ";
        4'hD: bus.keyword = "MOV   ";
        4'hE: bus.keyword = "BIC   ";
        default: bus.keyword = "MVN   ";
      endcase
    end else if (instr[27:26] == 2'b01) begin
      case ({instr[20], instr[22]})
        2'b10:   bus.keyword = "LDR   ";
        2'b11:   bus.keyword = "LDRB  ";
        2'b00:   bus.keyword = "STR   ";
        default: bus.keyword = "STRB  ";
      endcase
    end else if (instr[27:25] == 3'b101) begin
      bus.keyword = instr[24] ? "BL    " : "B     ";
    end
  end
`else
  assign bus.keyword = 48'h0;
`endif

endmodule

// File: tb/tb_id_decode_control.sv
// Scoreboard bench for id_decode_control: stimulus pushes expectations from
// a behavioural model, a negedge monitor pops and compares.
module tb_id_decode_control;

  logic clk = 1'b0;
  logic R;
  always #5 clk = ~clk;

  id_decode_control_if bus ();

  id_decode_control dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  model_flags;
  logic [3:0]  last_alu;

  // Pads a mnemonic to six ASCII characters
  function automatic logic [47:0] pad6(input string m);
    logic [47:0] r;
    r = {6{8'h20}};
    for (int i = 0; i < m.len() && i < 6; i++) r[47-8*i -: 8] = m[i];
    return r;
  endfunction

  function automatic logic [47:0] expKeyword(input logic [31:0] ins);
`ifdef CU_KEYWORD_EN
    string names[16] = '{"AND","EOR","SUB","RSB","ADD","ADC","SBC","RSC",
                         "TST","TEQ","CMP","CMN","ORR","MOV","BIC","MVN"};
    string m;
    if (ins == 32'h0) m = "NOP";
    else if (ins[27:26] == 2'b00) m = names[ins[24:21]];
    else if (ins[27:26] == 2'b01) begin
      if (ins[20]) m = "LDR"; else m = "STR";
      if (ins[22]) m = {m, "B"};
    end else if (ins[27:25] == 3'b101) begin
      if (ins[24]) m = "BL"; else m = "B";
    end else m = "UNDEF";
    return pad6(m);
`else
    return (ins == 32'h0) ? 48'h0 : 48'h0;
`endif
  endfunction

  // ARM condition meaning expressed with named flag booleans
  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] fl);
    bit n, z, c, v, base;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cond[0] ? !base : base;
  endfunction

  // Reference: expected packed outputs for one instruction
  function automatic logic [63:0] modelOut(input logic [31:0] ins, input logic stall,
                                           input logic [3:0] fl);
    logic [3:0] op; logic [1:0] am;
    bit s_en, ld, rf, sz, rw, en, bl, b, taken;
    op = 0; am = 0; s_en = 0; ld = 0; rf = 0; sz = 0; rw = 0; en = 0; bl = 0; b = 0;
    if (ins != 32'h0) begin
      if (ins[27:26] == 2'b00) begin
        op   = ins[24:21];
        s_en = ins[20];
        am   = ins[25] ? 2'd0 : 2'd1;
        rf   = !(op inside {4'd8, 4'd9, 4'd10, 4'd11});
      end else if (ins[27:26] == 2'b01) begin
        bit is_load;
        is_load = ins[20];
        op = ins[23] ? 4'd4 : 4'd2;
        am = ins[25] ? 2'd3 : 2'd2;
        ld = is_load; rf = is_load; rw = !is_load; en = 1; sz = ins[22];
      end else if (ins[27:25] == 3'b101) begin
        b = 1; bl = ins[24]; op = 4'd4;
      end
    end
    if (stall) begin
      op = 0; am = 0; s_en = 0; ld = 0; rf = 0; sz = 0; rw = 0; en = 0; bl = 0; b = 0;
    end
    taken = condHolds(ins[31:28], fl);
    return {expKeyword(ins), op, am, s_en, ld, rf, sz, rw, en, bl, b, b && taken, bl && taken};
  endfunction

  task automatic checkOutput(input logic [63:0] expv, input string nm);
    logic [63:0] act;
    act = {bus.keyword, bus.ID_opcode, bus.ID_AM, bus.ID_S_enable, bus.ID_load_instr,
           bus.ID_RF_enable, bus.ID_Size_enable, bus.ID_RW_enable, bus.ID_Enable_signal,
           bus.ID_BL_instr, bus.ID_B_instr, bus.Branch, bus.BranchL};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: outputs are settled by the negedge following each drive
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checkOutput(e, nm);
    end
  end

  task automatic drive(input logic [31:0] ins, input logic s, input logic [3:0] alu,
                       input logic [3:0] psr, input logic exs, input string nm);
    bus.instruction = ins;
    bus.S           = s;
    bus.alu_nzcv    = alu;
    bus.psr_flags   = psr;
    bus.ex_s_enable = exs;
    last_alu        = alu;
    exp_q.push_back(modelOut(ins, s, exs ? model_flags : psr));
    name_q.push_back(nm);
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic s, input logic [3:0] alu,
                               input logic [3:0] psr, input logic exs, input string nm);
    @(posedge clk);
    if (!R) model_flags = last_alu;
    #1;
    drive(ins, s, alu, psr, exs, nm);
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  cond;
    R = 1'b0;
    model_flags = 4'h0;
    last_alu = 4'h0;
    bus.instruction = 32'h0; bus.S = 0; bus.alu_nzcv = 0; bus.psr_flags = 0; bus.ex_s_enable = 0;
    #1 R = 1'b1;
    drive(32'h0, 1'b0, 4'h0, 4'h0, 1'b0, "reset_state");
    @(negedge clk);
    #2 R = 1'b0;

    applyStimulus(32'hE2921005, 0, 4'h0, 4'h0, 0, "adds_imm");
    applyStimulus(32'hE5D13004, 0, 4'h0, 4'h0, 0, "ldrb");
    applyStimulus(32'hE5D13004, 1, 4'h0, 4'h0, 0, "ldrb_stall");
    applyStimulus(32'hE1510002, 0, 4'h0, 4'h0, 0, "cmp_reg");
    applyStimulus(32'h0A000003, 0, 4'h0, 4'h4, 0, "beq_z_set");
    applyStimulus(32'h0A000003, 0, 4'h0, 4'h0, 0, "beq_z_clear");
    applyStimulus(32'h0A000003, 1, 4'h0, 4'h4, 0, "beq_stalled");
    applyStimulus(32'hEB000002, 0, 4'h4, 4'h0, 0, "bl_always");
    applyStimulus(32'h1A000001, 0, 4'h4, 4'h0, 1, "bne_alu_z");
    applyStimulus(32'hFA000000, 0, 4'h4, 4'hF, 0, "b_never");

    applyStimulus(32'h0, 0, 4'hF, 4'h0, 0, "load_flags_f");
    applyStimulus(32'h0A000003, 0, 4'hF, 4'h0, 1, "beq_flags_f");
    @(posedge clk);
    if (!R) model_flags = last_alu;
    #1;
    R = 1'b1;
    model_flags = 4'h0;
    drive(32'h0A000003, 0, 4'hF, 4'h0, 1, "beq_after_async_reset");
    applyStimulus(32'hAA000000, 0, 4'hF, 4'h0, 1, "bge_after_reset");
    @(negedge clk);
    #1 R = 1'b0;

    for (int i = 0; i < 400; i++) begin
      cond = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: ins = 32'h0;
        1: ins = {cond, 2'b00, 26'($urandom)};
        2: ins = {cond, 2'b01, 26'($urandom)};
        3: ins = {cond, 3'b101, 25'($urandom)};
        4: ins = {cond, ($urandom_range(0, 1) == 0) ? 3'b100 : {2'b11, 1'($urandom)},
                  25'($urandom)};
        default: ins = $urandom;
      endcase
      applyStimulus(ins, ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom),
                    1'($urandom), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
